// File: rtl/serial_alu_seq_if.sv
// Command/result handshake bundle for serial_alu_seq.
// The carry/zero flag wires exist only when SERIAL_ALU_FLAGS_EN is defined.
interface serial_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       s;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
`ifdef SERIAL_ALU_FLAGS_EN
  logic             carry;
  logic             zero;

  modport master (
    output in_valid, s, a, b, out_ready,
    input  in_ready, out_valid, result, carry, zero
  );
  modport slave (
    input  in_valid, s, a, b, out_ready,
    output in_ready, out_valid, result, carry, zero
  );
`else
  modport master (
    output in_valid, s, a, b, out_ready,
    input  in_ready, out_valid, result
  );
  modport slave (
    input  in_valid, s, a, b, out_ready,
    output in_ready, out_valid, result
  );
`endif
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one result bit per clock, LSB first, with a valid/ready command/result handshake.
// Optional carry/zero flag outputs are built when SERIAL_ALU_FLAGS_EN is defined.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_alu_seq_if.slave      bus,
  output logic [1:0]           o_dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE and out_valid only in DONE, so the
  // result must be consumed before the next command can be accepted.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_s;
  logic             r_carry;
  logic             w_accept;
  logic             w_last;
  logic             w_bit;
  logic             w_sum;
  logic             w_cout;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_last        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = SHIFT;
        end
      end
      SHIFT: begin
        // WIDTH bit cycles, then one cycle to publish the accumulated word.
        if (r_cnt == CW'(WIDTH)) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // r_b holds the already-conditioned B operand, so every arithmetic op is A + B + cin.
  always_comb begin
    w_sum  = r_a[0] ^ r_b[0] ^ r_carry;
    w_cout = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    case (r_s)
      3'b100:  w_bit = r_a[0] & r_b[0];
      3'b101:  w_bit = r_a[0] | r_b[0];
      3'b110:  w_bit = ~r_a[0];
      3'b111:  w_bit = r_a[0];
      default: w_bit = w_sum;
    endcase
  end

`ifdef SERIAL_ALU_FLAGS_EN
  logic r_flag_c;
  logic r_flag_z;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_s      <= '0;
      r_carry  <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_s     <= bus.s;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_carry <= (bus.s == 3'b001) || (bus.s == 3'b010);
      case (bus.s)
        3'b001:  r_b <= ~bus.b;
        3'b010:  r_b <= '0;
        3'b011:  r_b <= '1;
        3'b110:  r_b <= '0;
        3'b111:  r_b <= '0;
        default: r_b <= bus.b;
      endcase
    end else if (r_state == SHIFT) begin
      if (!w_last) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_acc   <= {w_bit, r_acc[WIDTH-1:1]};
        r_carry <= r_s[2] ? 1'b0 : w_cout;
        r_cnt   <= r_cnt + 1'b1;
      end else begin
        r_result <= r_acc;
`ifdef SERIAL_ALU_FLAGS_EN
        r_flag_c <= r_carry;
        r_flag_z <= (r_acc == '0);
`endif
      end
    end
  end

  assign bus.result  = r_result;
  assign o_dbg_state = r_state;
`ifdef SERIAL_ALU_FLAGS_EN
  assign bus.carry   = r_flag_c;
  assign bus.zero    = r_flag_z;
`endif
endmodule
